qspi_read_arbiter: RTL and testbench
====================================

// Module: qspi_read_arbiter
// PURPOSE
//  Shares the single QSPI flash read engine between two read requesters: instruction fetch (IF) and data (DM).
//  Holds all requests until spi_init signals flash initialisation complete.
//  Fixed priority to IF, with a starvation guard for DM and a per-transaction timeout.
//  Sits between the core-side fetch/load paths and the QSPI read engine, on the ACLK domain.
// PARAMETERS
//  ADDR_SIZE   24    flash byte address width
//  DATA_W      32    read word width
//  STARVE_MAX  4     consecutive IF wins while DM waits before DM is forced (>=1)
//  TIMEOUT     1024  max cycles waiting for eng_done before abort (>=2)
// PORTS
//  ACLK        in   1          clock
//  ARESETn     in   1          asynchronous active-low reset
//  init_done   in   1          spi_init flag_end_init (level)
//  if_req      in   1          IF read request (level, held until if_gnt)
//  if_addr     in   ADDR_SIZE  IF address, valid while if_req
//  if_gnt      out  1          1-cycle pulse: IF request accepted, address captured
//  if_rvalid   out  1          1-cycle pulse: IF read complete
//  if_rdata    out  DATA_W     IF read data, valid with if_rvalid
//  if_rerr     out  1          IF timeout flag, valid with if_rvalid
//  dm_req/dm_addr/dm_gnt/dm_rvalid/dm_rdata/dm_rerr   same as IF, data port
//  eng_start   out  1          1-cycle pulse: start engine read
//  eng_addr    out  ADDR_SIZE  engine address, stable from eng_start until completion
//  eng_abort   out  1          1-cycle pulse: abandon current engine read
//  eng_done    in   1          1-cycle pulse: engine read finished
//  eng_rdata   in   DATA_W     engine data, valid with eng_done
//  owner       out  2          00 none, 01 IF, 10 DM
//  busy        out  1          1 while in ISSUE or WAIT_DONE
// BEHAVIOUR
//  Reset: all outputs 0, state WAIT_INIT, starve_cnt 0, timer 0.
//  States: WAIT_INIT -> IDLE when init_done=1.
//          IDLE -> ISSUE when any req (arbitration decided this cycle).
//          IDLE -> WAIT_INIT when init_done=0.
//          ISSUE -> WAIT_DONE (single cycle).
//          WAIT_DONE -> RESPOND on eng_done or timeout.
//          RESPOND -> IDLE (single cycle).
//  Timing: req seen in IDLE at cycle N -> gnt, eng_start, eng_addr, owner registered at N+1 (ISSUE).
//          eng_done at cycle M -> rvalid, rdata at M+1 (RESPOND); next gnt earliest M+3.
//  Arbitration (IDLE only): DM wins if dm_req and (!if_req or starve_cnt==STARVE_MAX); otherwise IF wins.
//  starve_cnt: +1 when IF wins with dm_req=1; cleared when DM wins; saturates at STARVE_MAX.
//  One outstanding transaction total; reqs during ISSUE/WAIT_DONE/RESPOND are held, not granted.
//  Timeout: timer counts WAIT_DONE cycles. Reaching TIMEOUT-1 without eng_done -> eng_abort pulse,
//    rvalid with rerr=1 and rdata=0 next cycle.
//  eng_done coincident with the timeout cycle counts as success (rerr=0, no abort).
//  eng_done outside WAIT_DONE is ignored.
//  init_done falling during a transaction: transaction completes normally, then IDLE -> WAIT_INIT.
//  ARESETn asserted mid-transaction: immediate return to reset values; no eng_abort is issued.
//  rdata/rerr hold their last value between rvalid pulses; only the owning port's rvalid pulses.
// STRUCTURE
//  qspi_arb_pkg: state_t enum {WAIT_INIT, IDLE, ISSUE, WAIT_DONE, RESPOND}; owner_t enum {OWN_NONE, OWN_IF, OWN_DM}.
//  qspi_arb_pkg: starve/timer width localparams via $clog2.
//  Sub-module qspi_arb_prio: combinational pick plus starve_cnt register (ACLK/ARESETn);
//    inputs if_req, dm_req, take; outputs pick_if, pick_dm.
// TESTING
//  1. init_done=0, if_req=1 for 50 cycles -> no if_gnt/eng_start; init_done=1 -> if_gnt 2 cycles later.
//  2. IF read 0x000100, eng_done+eng_rdata=0xA5A5_1234 three cycles after start
//     -> if_rvalid next cycle, if_rdata=0xA5A5_1234, if_rerr=0.
//  3. if_req and dm_req held continuously, STARVE_MAX=4 -> grant order IF,IF,IF,IF,DM,IF,IF,IF,IF,DM.
//  4. No eng_done, TIMEOUT=16 -> eng_abort 16 cycles after eng_start, dm_rvalid/dm_rerr=1/rdata=0;
//     late eng_done then ignored.
//  5. ARESETn pulled low in WAIT_DONE -> all outputs 0 asynchronously;
//     after release plus init_done, pending req re-granted cleanly.
//  6. eng_done on exact timeout cycle -> rerr=0, data delivered, no eng_abort.

Source files
------------

// File: rtl/qspi_arb_pkg.sv
// qspi_arb_pkg: shared FSM/owner types, parameter defaults and counter-width helper
// for the QSPI read arbiter.
package qspi_arb_pkg;
    typedef enum logic [2:0] {WAIT_INIT, IDLE, ISSUE, WAIT_DONE, RESPOND} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_IF = 2'b01, OWN_DM = 2'b10} owner_t;
    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF = 1024;
    function automatic int cnt_w(input int m);
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction
endpackage

// File: rtl/qspi_arb_prio.sv
// qspi_arb_prio: fixed IF priority with a starvation counter that forces DM
// through after STARVE_MAX consecutive IF wins.
module qspi_arb_prio
    import qspi_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic if_req,
    input  logic dm_req,
    input  logic take,
    output logic pick_if,
    output logic pick_dm
);
    localparam int SW = cnt_w(STARVE_MAX);
    logic [SW-1:0] starve_cnt;
    logic starved;
    assign starved = starve_cnt == SW'(STARVE_MAX);
    assign pick_dm = dm_req && (!if_req || starved);
    assign pick_if = if_req && !pick_dm;
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            starve_cnt <= '0;
        else if (take)
            starve_cnt <= pick_dm ? '0 : (dm_req && !starved) ? starve_cnt + 1'b1 : starve_cnt;
    end
endmodule

// File: rtl/qspi_read_arbiter.sv
// qspi_read_arbiter: shares one QSPI read engine between instruction fetch and
// data requesters, gated on flash init, with per-transaction timeout.
module qspi_read_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int ADDR_SIZE  = 24,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 init_done,
    input  logic                 if_req,
    input  logic [ADDR_SIZE-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [DATA_W-1:0]    if_rdata,
    output logic                 if_rerr,
    input  logic                 dm_req,
    input  logic [ADDR_SIZE-1:0] dm_addr,
    output logic                 dm_gnt,
    output logic                 dm_rvalid,
    output logic [DATA_W-1:0]    dm_rdata,
    output logic                 dm_rerr,
    output logic                 eng_start,
    output logic [ADDR_SIZE-1:0] eng_addr,
    output logic                 eng_abort,
    input  logic                 eng_done,
    input  logic [DATA_W-1:0]    eng_rdata,
    output logic [1:0]           owner,
    output logic                 busy
);
    localparam int TW = cnt_w(TIMEOUT - 1);
    state_t state;
    owner_t own;
    logic [TW-1:0] timer;
    logic pick_if, pick_dm, take, tmo, fin, fin_if, fin_dm;
    qspi_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .ACLK(ACLK), .ARESETn(ARESETn), .if_req(if_req), .dm_req(dm_req),
        .take(take), .pick_if(pick_if), .pick_dm(pick_dm)
    );
    assign take = state == IDLE && init_done && (if_req || dm_req);
    assign tmo = state == WAIT_DONE && timer == TW'(TIMEOUT - 1);
    assign fin = state == WAIT_DONE && (eng_done || tmo);
    assign fin_if = fin && own == OWN_IF;
    assign fin_dm = fin && own == OWN_DM;
    // A completion landing on the timeout cycle wins, so abort only without eng_done
    assign eng_abort = tmo && !eng_done;
    assign busy = state == ISSUE || state == WAIT_DONE;
    assign owner = own;
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= WAIT_INIT;
            own       <= OWN_NONE;
            timer     <= '0;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            eng_start <= 1'b0;
            eng_addr  <= '0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_rerr   <= 1'b0;
            dm_rerr   <= 1'b0;
        end else begin
            if_gnt    <= take && pick_if;
            dm_gnt    <= take && pick_dm;
            eng_start <= take;
            if_rvalid <= fin_if;
            dm_rvalid <= fin_dm;
            timer     <= state == WAIT_DONE ? timer + 1'b1 : '0;
            if (take) begin
                eng_addr <= pick_dm ? dm_addr : if_addr;
                own      <= pick_dm ? OWN_DM : OWN_IF;
            end else if (state == RESPOND) begin
                own <= OWN_NONE;
            end
            if (fin_if) begin
                if_rdata <= eng_done ? eng_rdata : '0;
                if_rerr  <= !eng_done;
            end
            if (fin_dm) begin
                dm_rdata <= eng_done ? eng_rdata : '0;
                dm_rerr  <= !eng_done;
            end
            state <= state == WAIT_INIT ? (init_done ? IDLE : WAIT_INIT) :
                     state == IDLE      ? (!init_done ? WAIT_INIT : take ? ISSUE : IDLE) :
                     state == ISSUE     ? WAIT_DONE :
                     state == WAIT_DONE ? (fin ? RESPOND : WAIT_DONE) :
                     state == RESPOND   ? IDLE : WAIT_INIT;
        end
    end
endmodule

// File: tb/tb_qspi_read_arbiter.sv
// tb_qspi_read_arbiter: directed checks of init gating, reads, starvation order,
// timeout, async reset recovery and timeout-cycle completion.
module tb_qspi_read_arbiter;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        init_done = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0;
    logic [23:0] if_addr = '0, dm_addr = '0;
    logic        if_gnt, if_rvalid, if_rerr, dm_gnt, dm_rvalid, dm_rerr;
    logic [31:0] if_rdata, dm_rdata;
    logic        eng_start, eng_abort, busy;
    logic [23:0] eng_addr;
    logic        eng_done = 1'b0;
    logic [31:0] eng_rdata = '0;
    logic [1:0]  owner;
    int passed = 0, total = 0;

    qspi_read_arbiter #(.ADDR_SIZE(24), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .init_done(init_done),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_rerr(if_rerr),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .dm_rerr(dm_rerr),
        .eng_start(eng_start), .eng_addr(eng_addr), .eng_abort(eng_abort),
        .eng_done(eng_done), .eng_rdata(eng_rdata), .owner(owner), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_gnt(output logic gi, output logic gd);
        gi = 1'b0;
        gd = 1'b0;
        for (int i = 0; i < 20 && !(gi || gd); i++) begin
            tick();
            gi = if_gnt;
            gd = dm_gnt;
        end
        chk("gnt_seen", 64'(gi || gd), 64'd1);
    endtask

    initial begin
        logic gi, gd, saw;
        logic [9:0] dm_order;
        dm_order = 10'b10000_10000;
        // reset state
        tick();
        tick();
        chk("rst_outs", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, eng_start, eng_abort, busy, owner},
            64'd0);
        ARESETn = 1'b1;
        // 1: held request blocked until init_done
        if_req = 1'b1;
        if_addr = 24'h000100;
        saw = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            saw |= if_gnt | eng_start;
        end
        chk("no_gnt_pre_init", 64'(saw), 64'd0);
        init_done = 1'b1;
        tick();
        chk("gnt_1_cycle", 64'(if_gnt), 64'd0);
        tick();
        chk("gnt_2_cycles", {if_gnt, eng_start, busy, owner}, {1'b1, 1'b1, 1'b1, 2'b01});
        chk("eng_addr_if", 64'(eng_addr), 64'h000100);
        if_req = 1'b0;
        // 2: IF read completes three cycles after start
        tick();
        chk("gnt_pulse", {if_gnt, eng_start}, 64'd0);
        tick();
        tick();
        eng_done = 1'b1;
        eng_rdata = 32'hA5A5_1234;
        chk("no_abort_done", 64'(eng_abort), 64'd0);
        tick();
        eng_done = 1'b0;
        chk("if_rvalid", {if_rvalid, dm_rvalid, if_rerr, busy}, {1'b1, 1'b0, 1'b0, 1'b0});
        chk("if_rdata", 64'(if_rdata), 64'hA5A5_1234);
        tick();
        chk("rvalid_pulse", {if_rvalid, owner}, 64'd0);
        chk("if_rdata_hold", 64'(if_rdata), 64'hA5A5_1234);
        // 3: starvation order with both requests held
        if_req = 1'b1;
        dm_req = 1'b1;
        if_addr = 24'h000200;
        dm_addr = 24'h000300;
        eng_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            wait_gnt(gi, gd);
            chk($sformatf("order_%0d", i), {gi, gd}, dm_order[i] ? 64'b01 : 64'b10);
            chk($sformatf("addr_%0d", i), 64'(eng_addr), dm_order[i] ? 64'h000300 : 64'h000200);
            tick();
            eng_done = 1'b1;
            tick();
            eng_done = 1'b0;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        chk("dm_rdata_last", 64'(dm_rdata), 64'hDEAD_BEEF);
        // 4: DM timeout then late eng_done ignored
        dm_req = 1'b1;
        dm_addr = 24'h00ABCD;
        wait_gnt(gi, gd);
        dm_req = 1'b0;
        chk("dm_gnt", {gd, owner}, {1'b1, 2'b10});
        saw = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            saw |= eng_abort;
        end
        chk("no_early_abort", 64'(saw), 64'd0);
        tick();
        chk("abort_at_16", 64'(eng_abort), 64'd1);
        tick();
        chk("tmo_resp", {dm_rvalid, dm_rerr, if_rvalid, eng_abort}, {1'b1, 1'b1, 1'b0, 1'b0});
        chk("tmo_rdata", 64'(dm_rdata), 64'd0);
        eng_done = 1'b1;
        eng_rdata = 32'hFFFF_FFFF;
        tick();
        eng_done = 1'b0;
        tick();
        chk("late_done_ign", {dm_rvalid, if_rvalid, dm_rerr, eng_start, busy}, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        chk("late_rdata", 64'(dm_rdata), 64'd0);
        // 5: async reset during WAIT_DONE, then clean re-grant
        if_req = 1'b1;
        if_addr = 24'h123456;
        wait_gnt(gi, gd);
        tick();
        tick();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        ARESETn = 1'b0;
        #1;
        chk("async_rst", {busy, owner, eng_abort, eng_start, if_rerr, dm_rerr}, 64'd0);
        chk("async_rst_data", {eng_addr, if_rdata}, 64'd0);
        tick();
        tick();
        #2;
        ARESETn = 1'b1;
        tick();
        chk("post_rst_nognt", 64'(if_gnt), 64'd0);
        tick();
        chk("regrant", {if_gnt, owner}, {1'b1, 2'b01});
        chk("regrant_addr", 64'(eng_addr), 64'h123456);
        if_req = 1'b0;
        tick();
        eng_done = 1'b1;
        eng_rdata = 32'h5555_AAAA;
        tick();
        eng_done = 1'b0;
        chk("post_rst_read", {if_rvalid, if_rerr, if_rdata}, {1'b1, 1'b0, 32'h5555_AAAA});
        tick();
        // 6: eng_done on the exact timeout cycle succeeds
        dm_req = 1'b1;
        dm_addr = 24'h000040;
        wait_gnt(gi, gd);
        dm_req = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        eng_done = 1'b1;
        eng_rdata = 32'h600D_F00D;
        #1;
        chk("edge_no_abort", 64'(eng_abort), 64'd0);
        tick();
        eng_done = 1'b0;
        chk("edge_resp", {dm_rvalid, dm_rerr, eng_abort, dm_rdata}, {1'b1, 1'b0, 1'b0, 32'h600D_F00D});
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
